mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: resetn  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: exe_mem_valid  in  1  upstream (EXE) holds a valid instruction.
REQ-004 SHALL have ports: mem_allowin  out  1  MEM can accept a new instruction this cycle.
REQ-005 SHALL have ports: mem_wb_valid  out  1  MEM presents a valid instruction to WB.
REQ-006 SHALL have ports: wb_allowin  in  1  WB accepts this cycle.
REQ-007 SHALL have ports: exe_mem_bus  in  106  fields {gr_we[1], res_from_mem[1], ld_op[3], dest[5], pc[32], inst[32], alu_result[32]}, MSB first.
REQ-008 SHALL have ports: data_sram_rdata  in  32  synchronous SRAM read data, valid the cycle after EXE issued the address.
REQ-009 SHALL have ports: mem_wb_bus  out  102  {gr_we, dest, pc, inst, final_result}.
REQ-010 SHALL have ports: mem_wr_bus  out  38  {mem_en_bypass, dest, final_result}, forwarded to decode.

Function
REQ-011 SHALL use mem_ready_go = 1; mem_wb_valid = mem_valid & mem_ready_go; mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin).
REQ-012 SHALL, when mem_allowin=1, load mem_valid <= exe_mem_valid at the clock edge.
REQ-013 SHALL latch exe_mem_bus only when exe_mem_valid & mem_allowin; otherwise hold it.
REQ-014 SHALL run a read-data FSM: EMPTY (no instruction), FRESH (first resident cycle, live rdata valid), HELD (stalled, rdata captured).
REQ-015 SHALL transition: any state -> FRESH on accept; FRESH -> HELD when wb_allowin=0; FRESH/HELD -> EMPTY on leave with no new accept.
REQ-016 SHALL capture data_sram_rdata into a 32-bit hold register on the FRESH->HELD edge.
REQ-017 SHALL select load data from live data_sram_rdata in FRESH and from the hold register in HELD.
REQ-018 SHALL compute final_result = extended load data when res_from_mem=1, else alu_result.
REQ-019 SHALL drive mem_en_bypass = mem_valid & gr_we; all bus fields are combinational from the latched bus, with zero extra latency.
REQ-020 SHALL, on simultaneous leave and accept (wb_allowin=1, exe_mem_valid=1), enter FRESH for the new instruction; the hold register is not used.
REQ-021 SHALL make an instruction resident N cycles (N>=1) present identical final_result every cycle.

Reset
REQ-022 SHALL, while resetn=0, force mem_valid=0, FSM=EMPTY, hold register=0, latched bus=0.
REQ-023 SHALL thus output mem_wb_valid=0, mem_allowin=1, mem_en_bypass=0 during and immediately after reset.
REQ-024 SHALL drop a resident instruction on reset mid-operation with no WB handoff.

Configuration
REQ-025 SHALL, with MEM_SUBWORD_LOAD_EN defined, extract loads by ld_op: 000 W, 001 B, 010 H, 011 BU, 100 HU. Byte lane = alu_result[1:0]; half lane = alu_result[1]. Signed ops sign-extend, unsigned ops zero-extend. Reserved encodings behave as W.
REQ-026 SHALL, without MEM_SUBWORD_LOAD_EN, ignore ld_op and use the full 32-bit word; the bus width stays 106.

Structure
REQ-027 SHALL take bus widths (106/102/38) and ld_op encodings from shared package mycpu_pkg.
REQ-028 SHALL place lane select and extension in one combinational sub-module mem_load_ext (instantiated only when the macro is defined).

Verification
REQ-029 SHALL cover word load: alu_result=0x100, rdata=0xDEADBEEF, wb_allowin=1 -> mem_wb_bus final_result=0xDEADBEEF one cycle after accept.
REQ-030 SHALL cover stall capture: FRESH with rdata=0x12345678, wb_allowin=0 for 3 cycles, rdata changing to 0xFFFFFFFF -> final_result stays 0x12345678 throughout; mem_allowin=0.
REQ-031 SHALL cover (macro on) LD.B at addr[1:0]=3, rdata=0x80000000 -> 0xFFFFFF80; LD.HU at addr[1]=1, rdata=0x8001xxxx -> 0x00008001.
REQ-032 SHALL cover back-to-back: accept on consecutive cycles with wb_allowin=1 -> FSM stays FRESH, each final_result matches its own rdata.
REQ-033 SHALL cover non-load forwarding: gr_we=1, res_from_mem=0, dest=5, alu_result=7 -> mem_wr_bus={1,5,7}; with mem_valid=0 the bypass bit is 0.
REQ-034 SHALL cover async reset: resetn low mid-HELD -> mem_wb_valid=0 and mem_allowin=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared pipeline constants: inter-stage bus widths, load-op encodings and
// the MEM read-data FSM state codes.
package mycpu_pkg;

    localparam int EXE_MEM_BUS_W = 106;
    localparam int MEM_WB_BUS_W  = 102;
    localparam int MEM_WR_BUS_W  = 38;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_H  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_FRESH = 2'b01;
    localparam logic [1:0] ST_HELD  = 2'b10;

endpackage

// File: rtl/mem_load_ext.sv
// Sub-word load lane select and sign/zero extension; only instantiated by
// mem_stage when MEM_SUBWORD_LOAD_EN is defined.
import mycpu_pkg::*;

module mem_load_ext (
    input  logic [2:0]  i_ld_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    end

    // Reserved encodings fall through to a full-word load.
    always_comb begin
        o_data = i_word;
        case (i_ld_op)
            LD_B:    o_data = {{24{w_byte[7]}}, w_byte};
            LD_BU:   o_data = {24'd0, w_byte};
            LD_H:    o_data = {{16{w_half[15]}}, w_half};
            LD_HU:   o_data = {16'd0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EXE bus, keeps SRAM read data stable across
// WB stalls, and forms the WB / decode-bypass buses. Sub-word loads: MEM_SUBWORD_LOAD_EN.
import mycpu_pkg::*;

module mem_stage (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     exe_mem_valid,
    output logic                     mem_allowin,
    output logic                     mem_wb_valid,
    input  logic                     wb_allowin,
    input  logic [EXE_MEM_BUS_W-1:0] exe_mem_bus,
    input  logic [31:0]              data_sram_rdata,
    output logic [MEM_WB_BUS_W-1:0]  mem_wb_bus,
    output logic [MEM_WR_BUS_W-1:0]  mem_wr_bus,
    output logic [1:0]               dbg_fsm_state
);

    // Handshake: an instruction moves across a boundary on a clock edge when
    // the producer's valid and the consumer's allowin are both high.
    logic                     r_valid;
    logic [1:0]               r_state;
    logic [1:0]               w_next_state;
    logic [31:0]              r_hold;
    logic [EXE_MEM_BUS_W-1:0] r_bus;
    logic                     w_ready_go;
    logic                     w_accept;
    logic                     w_gr_we;
    logic                     w_res_from_mem;
    logic [2:0]               w_ld_op;
    logic [4:0]               w_dest;
    logic [31:0]              w_pc;
    logic [31:0]              w_inst;
    logic [31:0]              w_alu_result;
    logic [31:0]              w_ld_word;
    logic [31:0]              w_ld_data;
    logic [31:0]              w_final_result;

    assign w_ready_go   = 1'b1;
    assign mem_wb_valid = r_valid & w_ready_go;
    assign mem_allowin  = ~r_valid | (w_ready_go & wb_allowin);
    assign w_accept     = exe_mem_valid & mem_allowin;

    assign {w_gr_we, w_res_from_mem, w_ld_op, w_dest, w_pc, w_inst, w_alu_result} = r_bus;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_bus   <= '0;
        end else begin
            if (mem_allowin) r_valid <= exe_mem_valid;
            if (w_accept)    r_bus   <= exe_mem_bus;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_accept)
            w_next_state = ST_FRESH;
        else if (mem_allowin)
            w_next_state = ST_EMPTY;
        else if (r_state == ST_FRESH)
            w_next_state = ST_HELD;
    end

    // Live rdata is only valid in the first resident cycle, so grab it as
    // soon as a stall is seen there.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_EMPTY;
            r_hold  <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_FRESH && !mem_allowin) r_hold <= data_sram_rdata;
        end
    end

    assign w_ld_word = (r_state == ST_HELD) ? r_hold : data_sram_rdata;

`ifdef MEM_SUBWORD_LOAD_EN
    mem_load_ext u_load_ext (
        .i_ld_op   (w_ld_op),
        .i_addr_lo (w_alu_result[1:0]),
        .i_word    (w_ld_word),
        .o_data    (w_ld_data)
    );
`else
    logic w_unused_ld_op;
    assign w_unused_ld_op = ^w_ld_op;
    assign w_ld_data      = w_ld_word;
`endif

    assign w_final_result = w_res_from_mem ? w_ld_data : w_alu_result;
    assign mem_wb_bus     = {w_gr_we, w_dest, w_pc, w_inst, w_final_result};
    assign mem_wr_bus     = {r_valid & w_gr_we, w_dest, w_final_result};
    assign dbg_fsm_state  = r_state;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, word load, stall capture, sub-word
// loads (MEM_SUBWORD_LOAD_EN aware), back-to-back, forwarding, async reset.
module tb_mem_stage;

    localparam logic [2:0] T_LD_W  = 3'b000;
    localparam logic [2:0] T_LD_B  = 3'b001;
    localparam logic [2:0] T_LD_H  = 3'b010;
    localparam logic [2:0] T_LD_BU = 3'b011;
    localparam logic [2:0] T_LD_HU = 3'b100;
    localparam logic [1:0] S_EMPTY = 2'b00;
    localparam logic [1:0] S_FRESH = 2'b01;
    localparam logic [1:0] S_HELD  = 2'b10;

    logic         clk;
    logic         resetn;
    logic         exe_mem_valid;
    logic         mem_allowin;
    logic         mem_wb_valid;
    logic         wb_allowin;
    logic [105:0] exe_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic [101:0] mem_wb_bus;
    logic [37:0]  mem_wr_bus;
    logic [1:0]   dbg_fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .exe_mem_valid   (exe_mem_valid),
        .mem_allowin     (mem_allowin),
        .mem_wb_valid    (mem_wb_valid),
        .wb_allowin      (wb_allowin),
        .exe_mem_bus     (exe_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_wb_bus      (mem_wb_bus),
        .mem_wr_bus      (mem_wr_bus),
        .dbg_fsm_state   (dbg_fsm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [105:0] make_bus(input logic gr_we, input logic res_mem,
                                              input logic [2:0] ld_op, input logic [4:0] dest,
                                              input logic [31:0] pc, input logic [31:0] inst,
                                              input logic [31:0] alu);
        return {gr_we, res_mem, ld_op, dest, pc, inst, alu};
    endfunction

    task automatic test_reset();
        resetn = 1'b0; exe_mem_valid = 1'b0; wb_allowin = 1'b1;
        exe_mem_bus = '0; data_sram_rdata = 32'h0;
        #12;
        n_checks++; if (mem_wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", mem_wb_valid); end
        n_checks++; if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin: got %b want 1", mem_allowin); end
        n_checks++; if (mem_wr_bus[37] !== 1'b0) begin n_fail++; $display("FAIL reset_bypass: got %b want 0", mem_wr_bus[37]); end
        n_checks++; if (dbg_fsm_state !== S_EMPTY) begin n_fail++; $display("FAIL reset_state: got %b want %b", dbg_fsm_state, S_EMPTY); end
        n_checks++; if (mem_wb_bus !== 102'd0) begin n_fail++; $display("FAIL reset_wb_bus: got %h want 0", mem_wb_bus); end
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (mem_wb_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b want 0", mem_wb_valid); end
        n_checks++; if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL post_reset_allowin: got %b want 1", mem_allowin); end
    endtask

    task automatic test_word_load();
        exe_mem_valid = 1'b1; wb_allowin = 1'b1;
        exe_mem_bus = make_bus(1'b1, 1'b1, T_LD_W, 5'd3, 32'h1C00_0010, 32'h2880_0000, 32'h0000_0100);
        @(posedge clk); #1;
        exe_mem_valid = 1'b0; data_sram_rdata = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (mem_wb_valid !== 1'b1) begin n_fail++; $display("FAIL word_valid: got %b want 1", mem_wb_valid); end
        n_checks++; if (mem_wb_bus !== {1'b1, 5'd3, 32'h1C00_0010, 32'h2880_0000, 32'hDEAD_BEEF})
            begin n_fail++; $display("FAIL word_wb_bus: got %h want %h", mem_wb_bus, {1'b1, 5'd3, 32'h1C00_0010, 32'h2880_0000, 32'hDEAD_BEEF}); end
        n_checks++; if (dbg_fsm_state !== S_FRESH) begin n_fail++; $display("FAIL word_state: got %b want %b", dbg_fsm_state, S_FRESH); end
        @(posedge clk); #1;
        n_checks++; if (mem_wb_valid !== 1'b0) begin n_fail++; $display("FAIL word_leave_valid: got %b want 0", mem_wb_valid); end
        n_checks++; if (dbg_fsm_state !== S_EMPTY) begin n_fail++; $display("FAIL word_leave_state: got %b want %b", dbg_fsm_state, S_EMPTY); end
    endtask

    task automatic test_stall_capture();
        exe_mem_valid = 1'b1; wb_allowin = 1'b0;
        exe_mem_bus = make_bus(1'b1, 1'b1, T_LD_W, 5'd7, 32'h0000_0200, 32'h1111_0000, 32'h0000_0104);
        @(posedge clk); #1;
        exe_mem_bus = make_bus(1'b1, 1'b0, T_LD_W, 5'd8, 32'h0000_0300, 32'h2222_0000, 32'h0000_0999);
        data_sram_rdata = 32'h1234_5678;
        #1;
        n_checks++; if (mem_wb_bus[31:0] !== 32'h1234_5678) begin n_fail++; $display("FAIL stall_fresh_result: got %h want 12345678", mem_wb_bus[31:0]); end
        n_checks++; if (mem_allowin !== 1'b0) begin n_fail++; $display("FAIL stall_fresh_allowin: got %b want 0", mem_allowin); end
        n_checks++; if (dbg_fsm_state !== S_FRESH) begin n_fail++; $display("FAIL stall_fresh_state: got %b want %b", dbg_fsm_state, S_FRESH); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 data_sram_rdata = 32'hFFFF_FFFF;
            #1;
            n_checks++; if (mem_wb_bus[31:0] !== 32'h1234_5678) begin n_fail++; $display("FAIL stall_held_result[%0d]: got %h want 12345678", i, mem_wb_bus[31:0]); end
            n_checks++; if (mem_allowin !== 1'b0) begin n_fail++; $display("FAIL stall_held_allowin[%0d]: got %b want 0", i, mem_allowin); end
            n_checks++; if (dbg_fsm_state !== S_HELD) begin n_fail++; $display("FAIL stall_held_state[%0d]: got %b want %b", i, dbg_fsm_state, S_HELD); end
            n_checks++; if (mem_wb_bus[95:64] !== 32'h0000_0200) begin n_fail++; $display("FAIL stall_held_pc[%0d]: got %h want 00000200", i, mem_wb_bus[95:64]); end
        end
        exe_mem_valid = 1'b0; wb_allowin = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (mem_wb_valid !== 1'b0) begin n_fail++; $display("FAIL stall_leave_valid: got %b want 0", mem_wb_valid); end
        n_checks++; if (dbg_fsm_state !== S_EMPTY) begin n_fail++; $display("FAIL stall_leave_state: got %b want %b", dbg_fsm_state, S_EMPTY); end
    endtask

    task automatic test_subword_load();
        logic [2:0]  ops [6] = '{T_LD_B, T_LD_HU, T_LD_H, T_LD_BU, 3'b101, T_LD_B};
        logic [31:0] alus[6] = '{32'h103, 32'h102, 32'h100, 32'h101, 32'h100, 32'h102};
        logic [31:0] rds [6] = '{32'h8000_0000, 32'h8001_1234, 32'h0000_8765, 32'h0000_F000, 32'hCAFE_F00D, 32'h0042_0000};
`ifdef MEM_SUBWORD_LOAD_EN
        logic [31:0] exps[6] = '{32'hFFFF_FF80, 32'h0000_8001, 32'hFFFF_8765, 32'h0000_00F0, 32'hCAFE_F00D, 32'h0000_0042};
`else
        logic [31:0] exps[6] = '{32'h8000_0000, 32'h8001_1234, 32'h0000_8765, 32'h0000_F000, 32'hCAFE_F00D, 32'h0042_0000};
`endif
        wb_allowin = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exe_mem_valid = 1'b1;
            exe_mem_bus = make_bus(1'b1, 1'b1, ops[i], 5'd1, 32'h0000_0500 + 32'(i * 4), 32'h0, alus[i]);
            @(posedge clk); #1;
            exe_mem_valid = 1'b0; data_sram_rdata = rds[i];
            #1;
            n_checks++; if (mem_wb_bus[31:0] !== exps[i]) begin n_fail++; $display("FAIL subword[%0d]: got %h want %h", i, mem_wb_bus[31:0], exps[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rds[3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        wb_allowin = 1'b1; exe_mem_valid = 1'b1;
        exe_mem_bus = make_bus(1'b1, 1'b1, T_LD_W, 5'd2, 32'h0000_0400, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            data_sram_rdata = rds[i];
            if (i < 2) exe_mem_bus = make_bus(1'b1, 1'b1, T_LD_W, 5'd2, 32'h0000_0400 + 32'((i + 1) * 4), 32'h0, 32'((i + 1) * 16));
            else       exe_mem_valid = 1'b0;
            #1;
            n_checks++; if (mem_wb_bus[31:0] !== rds[i]) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h want %h", i, mem_wb_bus[31:0], rds[i]); end
            n_checks++; if (dbg_fsm_state !== S_FRESH) begin n_fail++; $display("FAIL b2b_state[%0d]: got %b want %b", i, dbg_fsm_state, S_FRESH); end
            n_checks++; if (mem_wb_bus[95:64] !== 32'h0000_0400 + 32'(i * 4)) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %h want %h", i, mem_wb_bus[95:64], 32'h0000_0400 + 32'(i * 4)); end
        end
        @(posedge clk); #1;
        n_checks++; if (dbg_fsm_state !== S_EMPTY) begin n_fail++; $display("FAIL b2b_drain_state: got %b want %b", dbg_fsm_state, S_EMPTY); end
    endtask

    task automatic test_forward();
        wb_allowin = 1'b1; exe_mem_valid = 1'b1; data_sram_rdata = 32'hAAAA_AAAA;
        exe_mem_bus = make_bus(1'b1, 1'b0, T_LD_W, 5'd5, 32'h0000_0600, 32'h0, 32'd7);
        @(posedge clk); #1;
        exe_mem_valid = 1'b0;
        #1;
        n_checks++; if (mem_wr_bus !== {1'b1, 5'd5, 32'd7}) begin n_fail++; $display("FAIL fwd_wr_bus: got %h want %h", mem_wr_bus, {1'b1, 5'd5, 32'd7}); end
        n_checks++; if (mem_wb_bus[31:0] !== 32'd7) begin n_fail++; $display("FAIL fwd_result: got %h want 7", mem_wb_bus[31:0]); end
        @(posedge clk); #1;
        n_checks++; if (mem_wr_bus[37] !== 1'b0) begin n_fail++; $display("FAIL fwd_idle_bypass: got %b want 0", mem_wr_bus[37]); end
        n_checks++; if (mem_wb_valid !== 1'b0) begin n_fail++; $display("FAIL fwd_idle_valid: got %b want 0", mem_wb_valid); end
        exe_mem_valid = 1'b1;
        exe_mem_bus = make_bus(1'b0, 1'b0, T_LD_W, 5'd9, 32'h0000_0604, 32'h0, 32'd3);
        @(posedge clk); #1;
        exe_mem_valid = 1'b0;
        #1;
        n_checks++; if (mem_wr_bus !== {1'b0, 5'd9, 32'd3}) begin n_fail++; $display("FAIL fwd_nowe_wr_bus: got %h want %h", mem_wr_bus, {1'b0, 5'd9, 32'd3}); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        wb_allowin = 1'b0; exe_mem_valid = 1'b1;
        exe_mem_bus = make_bus(1'b1, 1'b1, T_LD_W, 5'd6, 32'h0000_0700, 32'h0, 32'h0000_0108);
        @(posedge clk); #1;
        exe_mem_valid = 1'b0; data_sram_rdata = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        n_checks++; if (dbg_fsm_state !== S_HELD) begin n_fail++; $display("FAIL arst_pre_state: got %b want %b", dbg_fsm_state, S_HELD); end
        n_checks++; if (mem_wb_bus[31:0] !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL arst_pre_result: got %h want 5a5a5a5a", mem_wb_bus[31:0]); end
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (mem_wb_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", mem_wb_valid); end
        n_checks++; if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL arst_allowin: got %b want 1", mem_allowin); end
        n_checks++; if (mem_wr_bus[37] !== 1'b0) begin n_fail++; $display("FAIL arst_bypass: got %b want 0", mem_wr_bus[37]); end
        n_checks++; if (dbg_fsm_state !== S_EMPTY) begin n_fail++; $display("FAIL arst_state: got %b want %b", dbg_fsm_state, S_EMPTY); end
        n_checks++; if (mem_wb_bus !== 102'd0) begin n_fail++; $display("FAIL arst_wb_bus: got %h want 0", mem_wb_bus); end
        #2 resetn = 1'b1; wb_allowin = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (mem_wb_valid !== 1'b0) begin n_fail++; $display("FAIL arst_after_valid: got %b want 0", mem_wb_valid); end
        n_checks++; if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL arst_after_allowin: got %b want 1", mem_allowin); end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_stall_capture();
        test_subword_load();
        test_back_to_back();
        test_forward();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
